// File: rtl/des_ctrl_pkg.sv
// Shared state encoding, stage indices and key-schedule helpers for the
// DES round sequencer.
package des_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_IPERM  = 4'd1,
        S_KSETUP = 4'd2,
        S_EXPAND = 4'd3,
        S_XOR    = 4'd4,
        S_SBOX   = 4'd5,
        S_PBOX   = 4'd6,
        S_RNDEND = 4'd7,
        S_FPERM  = 4'd8,
        S_DONE   = 4'd9,
        S_ERROR  = 4'd10
    } state_e;

    localparam int unsigned ST_IPERM  = 0;
    localparam int unsigned ST_KSETUP = 1;
    localparam int unsigned ST_EXPAND = 2;
    localparam int unsigned ST_XOR    = 3;
    localparam int unsigned ST_SBOX   = 4;
    localparam int unsigned ST_PBOX   = 5;
    localparam int unsigned ST_RNDEND = 6;
    localparam int unsigned ST_FPERM  = 7;

    // Key indices whose round key uses a single left shift.
    localparam int unsigned SHIFT1_SET [4] = '{1, 2, 9, 16};

    function automatic logic is_stage(input state_e s);
        return (s >= S_IPERM) && (s <= S_FPERM);
    endfunction

    function automatic logic is_round(input state_e s);
        return (s >= S_EXPAND) && (s <= S_RNDEND);
    endfunction

    function automatic logic [2:0] stage_of(input state_e s);
        case (s)
            S_IPERM:  return 3'(ST_IPERM);
            S_KSETUP: return 3'(ST_KSETUP);
            S_EXPAND: return 3'(ST_EXPAND);
            S_XOR:    return 3'(ST_XOR);
            S_SBOX:   return 3'(ST_SBOX);
            S_PBOX:   return 3'(ST_PBOX);
            S_RNDEND: return 3'(ST_RNDEND);
            S_FPERM:  return 3'(ST_FPERM);
            default:  return 3'd0;
        endcase
    endfunction

    function automatic int unsigned key_index(input int unsigned rnd, input logic dec,
                                              input int unsigned nr);
        if (rnd == 0) return 0;
        if (dec) return nr + 1 - rnd;
        return rnd;
    endfunction

    function automatic logic shift2_of(input int unsigned k);
        if (k == 0) return 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (SHIFT1_SET[i] == k) return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage timeout counter: cleared on stage entry, counts while enabled,
// flags expiry in the cycle the count reaches all-ones.
module stage_watchdog #(
    parameter int unsigned WDOG_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WDOG_W-1:0] cnt_q, cnt_d, cnt_inc;

    always_comb begin
        cnt_inc = cnt_q + WDOG_W'(1);
        cnt_d   = cnt_q;
        if (clear)       cnt_d = '0;
        else if (enable) cnt_d = cnt_inc;
        // Depends only on registered count so the controller may feed its
        // next state back into clear without a combinational loop.
        expired = enable && (cnt_inc == '1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/des_round_sequencer.sv
// Control sequencer stepping the DES datapath through IP, key setup,
// NUM_ROUNDS Feistel rounds and FP with go/ack handshakes and a watchdog.
module des_round_sequencer
    import des_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 16,
    parameter int unsigned ROUND_W    = 5,
    parameter int unsigned WDOG_W     = 8,
    parameter int unsigned NUM_STAGES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode_dec,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_go,
    output logic [ROUND_W-1:0]    round,
    output logic [ROUND_W-1:0]    key_idx,
    output logic                  shift2,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [3:0]            state
);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ROUND_W-1:0]    rnd_q, rnd_d;
    logic                  err_q, err_d;
    logic [NUM_STAGES-1:0] go_q, go_d;
    logic [ROUND_W-1:0]    round_q, round_d;
    logic [ROUND_W-1:0]    key_q, key_d;
    logic                  sh_q, sh_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cur_ack, wd_clear, wd_expired;

    stage_watchdog #(.WDOG_W(WDOG_W)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (is_stage(state_q)),
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rnd_d   = rnd_q;
        err_d   = err_q;
        cur_ack = stage_ack[stage_of(state_q)];

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    mode_d  = mode_dec;
                    err_d   = 1'b0;
                    rnd_d   = ROUND_W'(1);
                    state_d = S_IPERM;
                end else if (abort && state_q == S_ERROR) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (abort) begin
                    state_d = S_IDLE;
                    rnd_d   = '0;
                end else if (cur_ack) begin
                    case (state_q)
                        S_IPERM:  state_d = S_KSETUP;
                        S_KSETUP: state_d = S_EXPAND;
                        S_EXPAND: state_d = S_XOR;
                        S_XOR:    state_d = S_SBOX;
                        S_SBOX:   state_d = S_PBOX;
                        S_PBOX:   state_d = S_RNDEND;
                        S_RNDEND: begin
                            if (32'(rnd_q) < NUM_ROUNDS) begin
                                rnd_d   = rnd_q + ROUND_W'(1);
                                state_d = S_EXPAND;
                            end else begin
                                state_d = S_FPERM;
                            end
                        end
                        S_FPERM: begin
                            rnd_d   = '0;
                            state_d = S_DONE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else if (wd_expired) begin
                    rnd_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end
            end
        endcase

        wd_clear = (state_d != state_q) || !is_stage(state_q);

        // All outputs are computed from next-state values and registered.
        round_d = is_round(state_d) ? rnd_d : '0;
        key_d   = ROUND_W'(key_index(32'(round_d), mode_d, NUM_ROUNDS));
        sh_d    = shift2_of(32'(key_d));
        busy_d  = is_stage(state_d);
        done_d  = (state_d == S_DONE) && (state_q != S_DONE);
        go_d    = '0;
        if ((state_d != state_q) && is_stage(state_d)) go_d[stage_of(state_d)] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            rnd_q   <= '0;
            err_q   <= 1'b0;
            go_q    <= '0;
            round_q <= '0;
            key_q   <= '0;
            sh_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rnd_q   <= rnd_d;
            err_q   <= err_d;
            go_q    <= go_d;
            round_q <= round_d;
            key_q   <= key_d;
            sh_q    <= sh_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign stage_go = go_q;
    assign round    = round_q;
    assign key_idx  = key_q;
    assign shift2   = sh_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign state    = state_q;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench: 16-round instance with a short watchdog plus an 8-round
// instance with permanently asserted acks.
module tb_des_round_sequencer;
    import des_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, mode_dec = 1'b0, abort = 1'b0;
    logic [7:0] stage_ack = '0;
    logic [7:0] stage_go;
    logic [4:0] round, key_idx;
    logic       shift2, busy, done, err;
    logic [3:0] state;

    logic       start8 = 1'b0;
    logic [7:0] ack8 = '1;
    logic [7:0] go8;
    logic [4:0] round8, key8;
    logic       sh8, busy8, done8, err8;
    logic [3:0] state8;

    des_round_sequencer #(.NUM_ROUNDS(16), .ROUND_W(5), .WDOG_W(4), .NUM_STAGES(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode_dec(mode_dec), .abort(abort),
        .stage_ack(stage_ack), .stage_go(stage_go), .round(round), .key_idx(key_idx),
        .shift2(shift2), .busy(busy), .done(done), .err(err), .state(state)
    );

    des_round_sequencer #(.NUM_ROUNDS(8), .ROUND_W(5), .WDOG_W(4), .NUM_STAGES(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .mode_dec(1'b0), .abort(1'b0),
        .stage_ack(ack8), .stage_go(go8), .round(round8), .key_idx(key8),
        .shift2(sh8), .busy(busy8), .done(done8), .err(err8), .state(state8)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Responder/monitor state
    int         ack_mode = 0;     // 0: ack one cycle after go, 1: ack held high
    int         hold_rnd = 0;     // round whose SBOX ack is withheld
    int         abort_rnd = 0;    // round whose PBOX ack is accompanied by abort
    logic       abort_pend = 1'b0;
    logic       sb_flag = 1'b0;
    logic [7:0] pend = '0;
    int n_go, n_exp, n_done, n_busy, n_dup, sbox_cycles;
    int rec_key [16], rec_sh [16], rec_rnd [16];
    int n_go8 = 0, n_exp8 = 0, n_done8 = 0, last_key8 = 0, last_sh8 = 0, last_rnd8 = 0;

    task automatic clear_stats();
        n_go = 0; n_exp = 0; n_done = 0; n_busy = 0; n_dup = 0; sbox_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            rec_key[i] = -1; rec_sh[i] = -1; rec_rnd[i] = -1;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            pend      = '0;
            stage_ack = '0;
            abort     = 1'b0;
        end else begin
            if (abort_pend) begin
                check_eq("abort_idle", {busy, done, round, stage_go}, 0);
                abort_pend = 1'b0;
            end
            if ($countones(stage_go) > 1) n_dup++;
            if (stage_go != 0) n_go++;
            if (busy) n_busy++;
            if (done) n_done++;
            if (stage_go[ST_EXPAND]) begin
                if (n_exp < 16) begin
                    rec_key[n_exp] = int'(key_idx);
                    rec_sh[n_exp]  = int'(shift2);
                    rec_rnd[n_exp] = int'(round);
                end
                n_exp++;
            end
            if (hold_rnd != 0 && stage_go[ST_SBOX] && int'(round) == hold_rnd) sb_flag = 1'b1;
            if (sb_flag) begin
                if (busy) sbox_cycles++;
                else sb_flag = 1'b0;
            end
            abort = 1'b0;
            if (ack_mode == 1) stage_ack = '1;
            else begin
                stage_ack = pend;
                pend      = stage_go;
            end
            if (hold_rnd != 0 && int'(round) == hold_rnd) stage_ack[ST_SBOX] = 1'b0;
            if (abort_rnd != 0 && int'(round) == abort_rnd && stage_ack[ST_PBOX] && stage_go == 0) begin
                abort      = 1'b1;
                abort_rnd  = 0;
                abort_pend = 1'b1;
            end
        end
        if (go8 != 0) n_go8++;
        if (go8[ST_EXPAND]) begin
            n_exp8++;
            last_key8 = int'(key8); last_sh8 = int'(sh8); last_rnd8 = int'(round8);
        end
        if (done8) n_done8++;
    end

    task automatic run_block(input logic dec);
        mode_dec = dec;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        mode_dec = 1'b0;
        check_eq("busy_after_start", busy, 1);
        for (int k = 0; k < 4000 && busy; k++) @(negedge clk);
        check_eq("run_ends", busy, 0);
        @(negedge clk);
    endtask

    // Hand-written shift2 for key indices 1..16 (bit k-1): 0,0,1,1,1,1,1,1,0,1,1,1,1,1,1,0
    logic [15:0] sh_tab = 16'h7EFC;

    task automatic check_rounds(input logic dec);
        int k;
        for (int i = 0; i < 16; i++) begin
            k = dec ? 16 - i : i + 1;
            check_eq($sformatf("rnd%0d_round", i + 1), rec_rnd[i], i + 1);
            check_eq($sformatf("rnd%0d_key", i + 1), rec_key[i], k);
            check_eq($sformatf("rnd%0d_shift2", i + 1), rec_sh[i], sh_tab[k-1]);
        end
    endtask

    initial begin
        clear_stats();
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {stage_go, round, key_idx, shift2, busy, done, err, state}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Encrypt, ack one cycle after go
        clear_stats();
        run_block(1'b0);
        check_eq("enc_expand_pulses", n_exp, 16);
        check_eq("enc_go_total", n_go, 83);
        check_eq("enc_busy_cycles", n_busy, 166);
        check_eq("enc_done_pulses", n_done, 1);
        check_eq("enc_onehot", n_dup, 0);
        check_eq("enc_idle_after", {round, key_idx, err}, 0);
        check_rounds(1'b0);

        // Decrypt, same acks
        clear_stats();
        run_block(1'b1);
        check_eq("dec_expand_pulses", n_exp, 16);
        check_eq("dec_go_total", n_go, 83);
        check_eq("dec_done_pulses", n_done, 1);
        check_rounds(1'b1);

        // Ack held high: one cycle per stage
        clear_stats();
        ack_mode = 1;
        run_block(1'b0);
        check_eq("hold_go_total", n_go, 83);
        check_eq("hold_busy_cycles", n_busy, 83);
        check_eq("hold_onehot", n_dup, 0);
        check_eq("hold_done_pulses", n_done, 1);
        check_rounds(1'b0);
        ack_mode = 0;

        // Watchdog: SBOX ack withheld in round 3
        clear_stats();
        hold_rnd = 3;
        run_block(1'b0);
        check_eq("wdog_sbox_cycles", sbox_cycles, 15);
        check_eq("wdog_err_state", {err, busy, round, done}, 64'h1 << 7);
        check_eq("wdog_no_done", n_done, 0);
        check_eq("wdog_expand_count", n_exp, 3);
        n_go = 0;
        repeat (4) @(negedge clk);
        check_eq("wdog_no_more_go", n_go, 0);
        check_eq("wdog_err_sticky", err, 1);
        hold_rnd = 0;
        clear_stats();
        run_block(1'b0);
        check_eq("wdog_recover_done", n_done, 1);
        check_eq("wdog_recover_err", err, 0);
        check_rounds(1'b0);

        // Abort in PBOX of round 7 alongside its ack
        clear_stats();
        abort_rnd = 7;
        run_block(1'b0);
        check_eq("abort_no_done", n_done, 0);
        check_eq("abort_expand_count", n_exp, 7);
        check_eq("abort_state", {busy, round, err}, 0);
        clear_stats();
        run_block(1'b1);
        check_eq("post_abort_done", n_done, 1);
        check_rounds(1'b1);

        // Reset while in XOR of round 2
        clear_stats();
        begin
            int k;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (k = 0; k < 500; k++) begin
                @(negedge clk);
                if (stage_go[ST_XOR] && round == 5'd2) break;
            end
            check_eq("xor_reached", k < 500, 1);
        end
        reset = 1'b0;
        #1;
        check_eq("reset_mid_outputs", {stage_go, round, key_idx, shift2, busy, done, err, state}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_stats();
        run_block(1'b0);
        check_eq("post_reset_done", n_done, 1);
        check_eq("post_reset_go_total", n_go, 83);
        check_rounds(1'b0);

        // 8-round instance, acks held high
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int k = 0; k < 500 && n_done8 == 0; k++) @(negedge clk);
        @(negedge clk);
        check_eq("nr8_done_pulses", n_done8, 1);
        check_eq("nr8_expand_pulses", n_exp8, 8);
        check_eq("nr8_go_total", n_go8, 43);
        check_eq("nr8_last_round", last_rnd8, 8);
        check_eq("nr8_last_key", last_key8, 8);
        check_eq("nr8_last_shift2", last_sh8, 1);
        check_eq("nr8_idle", {busy8, round8, err8}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
